// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle expiry pulse,
// optional auto-reload and a saturating count of expiries.
module countdown_timer #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WIDTH-1:0]  data,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              auto_reload,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [PCNT_W-1:0] periods
);
    typedef enum logic [1:0] {IDLE, RUN, RELOAD} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] reload, reload_n, count_n;
    logic             expire;

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        expire   = 1'b0;
        if (stop) begin
            state_n = IDLE;
        end else if (load) begin
            count_n  = data;
            reload_n = data;
            if (state == IDLE && start) begin
                expire  = (data == '0);
                state_n = expire ? IDLE : RUN;
            end else if (state == RELOAD) begin
                state_n = RUN;
            end
        end else begin
            case (state)
                IDLE: if (start) begin
                    expire  = (count == '0);
                    state_n = expire ? IDLE : RUN;
                end
                // a zero count in RUN (only reachable via a zero load) expires rather than wraps
                RUN: if (!pause) begin
                    expire  = (count <= WIDTH'(1));
                    count_n = expire ? '0 : count - 1'b1;
                    if (expire) state_n = (auto_reload && reload != '0) ? RELOAD : IDLE;
                end
                RELOAD: begin
                    count_n = reload;
                    state_n = RUN;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            reload  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            periods <= '0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            reload <= reload_n;
            busy   <= (state_n != IDLE);
            done   <= expire;
            if (expire && periods != '1) periods <= periods + 1'b1;
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios checked against a behavioural model
// every cycle, plus hand-computed literal checks; a PCNT_W=2 copy checks saturation.
module tb_countdown_timer;
    logic       clk = 0, rst_n = 0, load = 0, start = 0, pause = 0, stop = 0, auto_reload = 0;
    logic [3:0] data = 0, count, count2;
    logic       busy, done, busy2, done2;
    logic [7:0] periods;
    logic [1:0] periods2;
    int         tests = 0, fails = 0;
    int         m_count, m_reload, m_mode, m_per;
    bit         m_done;

    always #5 clk = ~clk;

    countdown_timer dut (.clk(clk), .rst_n(rst_n), .load(load), .data(data), .start(start),
        .pause(pause), .stop(stop), .auto_reload(auto_reload), .count(count), .busy(busy),
        .done(done), .periods(periods));
    countdown_timer #(.WIDTH(4), .PCNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .load(load),
        .data(data), .start(start), .pause(pause), .stop(stop), .auto_reload(auto_reload),
        .count(count2), .busy(busy2), .done(done2), .periods(periods2));

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // mode: 0 idle, 1 counting, 2 reloading; periods kept unbounded and clipped on compare
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0; m_reload = 0; m_mode = 0; m_per = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (stop) m_mode = 0;
            else if (load) begin
                m_count = data; m_reload = data;
                if (m_mode == 0 && start) begin
                    if (data == 0) begin m_done = 1; m_per++; end
                    else m_mode = 1;
                end else if (m_mode == 2) m_mode = 1;
            end else if (m_mode == 0) begin
                if (start && m_count == 0) begin m_done = 1; m_per++; end
                else if (start) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!pause && m_count > 1) m_count--;
                else if (!pause) begin
                    m_count = 0; m_done = 1; m_per++;
                    m_mode = (auto_reload && m_reload != 0) ? 2 : 0;
                end
            end else begin
                m_count = m_reload; m_mode = 1;
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        chk("count", count, m_count);
        chk("busy", busy, int'(m_mode != 0));
        chk("done", done, int'(m_done));
        chk("periods", periods, m_per > 255 ? 255 : m_per);
        chk("count2", count2, m_count);
        chk("busy2", busy2, int'(m_mode != 0));
        chk("done2", done2, int'(m_done));
        chk("periods2", periods2, m_per > 3 ? 3 : m_per);
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {load, start, pause, stop, auto_reload} = '0;
        data = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_periods", periods, 0);
        @(negedge clk);
        #2 rst_n = 1;
        tick(1);
    endtask

    initial begin
        do_reset();
        // zero-count start, then async reset mid-count
        start = 1; tick(1);
        chk("z_done", done, 1); chk("z_busy", busy, 0); chk("z_periods", periods, 1);
        start = 0; tick(1);
        chk("z_done_off", done, 0);
        load = 1; data = 5; start = 1; tick(1);
        load = 0; start = 0; tick(1);
        chk("mid_count", count, 4); chk("mid_busy", busy, 1);
        do_reset();
        // one-shot from 3
        load = 1; data = 3; start = 1; tick(1);
        chk("os_c3", count, 3);
        load = 0; start = 0; tick(1);
        chk("os_c2", count, 2);
        tick(1);
        chk("os_c1", count, 1); chk("os_done_early", done, 0);
        tick(1);
        chk("os_c0", count, 0); chk("os_done", done, 1); chk("os_busy", busy, 0);
        chk("os_periods", periods, 1);
        tick(1);
        chk("os_done_off", done, 0);
        do_reset();
        // periodic from 2, then stop mid-count
        load = 1; data = 2; start = 1; auto_reload = 1; tick(1);
        load = 0; start = 0; tick(11);
        chk("per_done", done, 1); chk("per_periods", periods, 4); chk("per_busy", busy, 1);
        tick(2);
        chk("per_c1", count, 1);
        stop = 1; tick(1);
        chk("stop_count", count, 1); chk("stop_busy", busy, 0);
        stop = 0; tick(2);
        chk("stop_hold", count, 1); chk("stop_periods", periods, 4);
        do_reset();
        // pause for three cycles after first decrement
        load = 1; data = 5; start = 1; tick(1);
        load = 0; start = 0; tick(1);
        chk("pz_c4", count, 4);
        pause = 1; tick(3);
        chk("pz_hold", count, 4);
        pause = 0; tick(3);
        chk("pz_c1", count, 1); chk("pz_early", done, 0);
        tick(1);
        chk("pz_done", done, 1); chk("pz_c0", count, 0);
        do_reset();
        // reload while running, then stop beats load
        load = 1; data = 6; start = 1; tick(1);
        load = 0; start = 0; tick(2);
        chk("ld_c4", count, 4);
        load = 1; data = 9; tick(1);
        chk("ld_c9", count, 9); chk("ld_busy", busy, 1);
        load = 0; tick(2);
        chk("ld_c7", count, 7);
        stop = 1; load = 1; data = 2; tick(1);
        chk("sl_count", count, 7); chk("sl_busy", busy, 0);
        stop = 0; load = 0; tick(1);
        chk("sl_hold", count, 7);
        do_reset();
        // saturation of the 2-bit expiry counter
        load = 1; data = 1; start = 1; auto_reload = 1; tick(1);
        load = 0; start = 0; tick(9);
        chk("sat_p8", periods, 5); chk("sat_p2", periods2, 3); chk("sat_done", done, 1);
        tick(2);
        chk("sat_p8b", periods, 6); chk("sat_p2b", periods2, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
